uart_fifo_param: RTL and testbench



---
 rtl/uart_fifo_param.sv | 178 +++++++++++++++++
 tb/tb_uart_fifo_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// ---------------------------------------------------------------------------
// uart_fifo_param
// 16550-style receive/transmit FIFO with a per-entry line-status tag.
// Circular buffer with first-word fall-through read port, occupancy count,
// sticky overrun, one-cycle underrun pulse, programmable trigger level and
// an "error somewhere in the FIFO" flag (LSR bit 7 equivalent).
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          enable for push_in / pop_in (flush, status_clr always act)
//   flush       synchronous clear of contents, count, errcnt, overrun
//   status_clr  synchronous clear of sticky overrun
//   push_in     write request, data din / tag_in
//   pop_in      read request
//   threshold   trigger level (0 disables thr_trigger)
//   dout        head data, zero while empty
//   tag_out     head tag, zero while empty
//   count       occupancy 0..FIFO_DEPTH
//   empty/full  occupancy flags from the registered count
//   overrun     sticky: write attempted while full without a pop
//   underrun    one-cycle pulse: read attempted while empty
//   thr_trigger count >= threshold (threshold != 0)
//   err_in_fifo at least one stored entry carries a nonzero tag
// ---------------------------------------------------------------------------
module uart_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              flush,
  input  logic                              status_clr,
  input  logic                              push_in,
  input  logic                              pop_in,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic [TAG_WIDTH-1:0]              tag_in,
  input  logic [$clog2(FIFO_DEPTH):0]       threshold,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic [TAG_WIDTH-1:0]              tag_out,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  output logic                              empty,
  output logic                              full,
  output logic                              overrun,
  output logic                              underrun,
  output logic                              thr_trigger,
  output logic                              err_in_fifo
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + TAG_WIDTH;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(FIFO_DEPTH);

  // A tag is an error marker when any of its status bits is set.
  function automatic logic tag_err(input logic [TAG_WIDTH-1:0] t);
    return |t;
  endfunction

  logic [EW-1:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [AW:0]    count_r;
  logic [AW:0]    errcnt_r;
  logic           overrun_r;
  logic           underrun_r;

  logic           empty_s;
  logic           full_s;
  logic           push_s;
  logic           pop_s;
  logic           ovr_set_s;
  logic [EW-1:0]  head_s;
  logic [AW:0]    count_nxt_s;
  logic [AW:0]    errcnt_nxt_s;
  logic           err_push_s;
  logic           err_pop_s;

  assign empty_s = (count_r == {(AW + 1){1'b0}});
  assign full_s  = (count_r == CNT_MAX);

  // A pop is only accepted when data exists; a push into a full FIFO is
  // accepted only if the head is leaving in the same cycle.
  assign pop_s     = en & pop_in & ~empty_s & ~flush;
  assign push_s    = en & push_in & (~full_s | pop_s) & ~flush;
  assign ovr_set_s = en & push_in & full_s & ~pop_in;

  assign head_s     = mem_r[rd_ptr_r];
  assign err_push_s = push_s & tag_err(tag_in);
  assign err_pop_s  = pop_s & tag_err(head_s[EW-1:DATA_WIDTH]);

  // Next occupancy and next error-entry count from accepted push/pop.
  always_comb begin
    count_nxt_s  = count_r;
    errcnt_nxt_s = errcnt_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    case ({err_push_s, err_pop_s})
      2'b10:   errcnt_nxt_s = errcnt_r + CNT_ONE;
      2'b01:   errcnt_nxt_s = errcnt_r - CNT_ONE;
      default: errcnt_nxt_s = errcnt_r;
    endcase
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {tag_in, din};
    end
  end

  // Pointers, occupancy and error-entry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      errcnt_r <= {(AW + 1){1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      errcnt_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r  <= count_nxt_s;
      errcnt_r <= errcnt_nxt_s;
    end
  end

  // Sticky overrun: flush clears, a new set beats status_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (flush) begin
      overrun_r <= 1'b0;
    end else if (ovr_set_s) begin
      overrun_r <= 1'b1;
    end else if (status_clr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Underrun is a single-cycle pulse of the attempt seen on the prior edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= en & pop_in & empty_s;
    end
  end

  // Fall-through read port gated to zero while empty (stale memory hidden).
  assign {tag_out, dout} = empty_s ? {EW{1'b0}} : head_s;

  assign count       = count_r;
  assign empty       = empty_s;
  assign full        = full_s;
  assign overrun     = overrun_r;
  assign underrun    = underrun_r;
  assign thr_trigger = (threshold != {(AW + 1){1'b0}}) & (count_r >= threshold);
  assign err_in_fifo = (errcnt_r != {(AW + 1){1'b0}});

endmodule

// File: tb/tb_uart_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_param
// Self-checking bench for uart_fifo_param (DEPTH 16, WIDTH 8, TAG 3).
// A queue-based model tracks the FIFO contents and status flags; every
// cycle all outputs are compared against it, plus directed spot checks.
// ---------------------------------------------------------------------------
module tb_uart_fifo_param;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int TW = 3;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          flush;
  logic          status_clr;
  logic          push_in;
  logic          pop_in;
  logic [DW-1:0] din;
  logic [TW-1:0] tag_in;
  logic [AW:0]   threshold;
  logic [DW-1:0] dout;
  logic [TW-1:0] tag_out;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overrun;
  logic          underrun;
  logic          thr_trigger;
  logic          err_in_fifo;

  int checks_cnt;
  int errors_cnt;

  // Reference model state: queue of {tag, data}, plus status flags.
  logic [TW+DW-1:0] mq[$];
  logic             ovr_m;
  logic             und_m;

  uart_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .status_clr(status_clr),
    .push_in(push_in), .pop_in(pop_in), .din(din), .tag_in(tag_in),
    .threshold(threshold), .dout(dout), .tag_out(tag_out), .count(count),
    .empty(empty), .full(full), .overrun(overrun), .underrun(underrun),
    .thr_trigger(thr_trigger), .err_in_fifo(err_in_fifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ovr_m = 1'b0;
    und_m = 1'b0;
  endtask

  // Compare every DUT output with what the model predicts.
  task automatic check_all();
    int sz;
    bit err;
    sz = mq.size();
    err = 1'b0;
    foreach (mq[i]) if (mq[i][TW+DW-1:DW] != 0) err = 1'b1;
    check_val("count", 32'(count), 32'(sz));
    check_val("empty", 32'(empty), 32'(sz == 0));
    check_val("full", 32'(full), 32'(sz == DEPTH));
    check_val("dout", 32'(dout), (sz == 0) ? 32'd0 : 32'(mq[0][DW-1:0]));
    check_val("tag_out", 32'(tag_out), (sz == 0) ? 32'd0 : 32'(mq[0][TW+DW-1:DW]));
    check_val("overrun", 32'(overrun), 32'(ovr_m));
    check_val("underrun", 32'(underrun), 32'(und_m));
    check_val("thr_trigger", 32'(thr_trigger), 32'((threshold != 0) && (sz >= int'(threshold))));
    check_val("err_in_fifo", 32'(err_in_fifo), 32'(err));
  endtask

  // One clock cycle: drive at negedge, predict, clock, compare at next negedge.
  task automatic step(input logic e, input logic f, input logic sc, input logic pu,
                      input logic po, input logic [DW-1:0] d, input logic [TW-1:0] t);
    int sz;
    bit pop_ok, push_ok, ovr_n, und_n;
    en = e; flush = f; status_clr = sc; push_in = pu; pop_in = po; din = d; tag_in = t;
    sz = mq.size();
    pop_ok  = e && po && (sz > 0) && !f;
    push_ok = e && pu && ((sz < DEPTH) || pop_ok) && !f;
    und_n   = e && po && (sz == 0);
    if (f) ovr_n = 1'b0;
    else if (e && pu && (sz == DEPTH) && !po) ovr_n = 1'b1;
    else if (sc) ovr_n = 1'b0;
    else ovr_n = ovr_m;
    @(posedge clk);
    @(negedge clk);
    if (f) mq.delete();
    else begin
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back({t, d});
    end
    ovr_m = ovr_n;
    und_m = und_n;
    check_all();
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] t);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, d, t);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; status_clr = 1'b0;
    push_in = 1'b0; pop_in = 1'b0; din = 8'h00; tag_in = 3'd0; threshold = 5'd1;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_thr", 32'(thr_trigger), 32'd0);
    check_val("rst_err", 32'(err_in_fifo), 32'd0);
    check_val("rst_dout", 32'(dout), 32'd0);
    check_val("rst_tag", 32'(tag_out), 32'd0);
    rst_n = 1'b1;
    threshold = 5'd0;

    // Fill, overrun, sticky hold, status clear.
    for (int i = 1; i <= 16; i++) push(8'(i), 3'd0);
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_count", 32'(count), 32'd16);
    push(8'h77, 3'd0);
    check_val("ovr_set", 32'(overrun), 32'd1);
    idle();
    check_val("ovr_hold", 32'(overrun), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    check_val("ovr_clr", 32'(overrun), 32'd0);

    // Drain in order, then underrun pulse.
    for (int i = 1; i <= 16; i++) begin
      check_val("drain_dout", 32'(dout), 32'(i));
      pop();
    end
    check_val("drain_empty", 32'(empty), 32'd1);
    pop();
    check_val("und_pulse", 32'(underrun), 32'd1);
    check_val("und_count", 32'(count), 32'd0);
    idle();
    check_val("und_gone", 32'(underrun), 32'd0);

    // Simultaneous push/pop while full.
    for (int i = 1; i <= 16; i++) push(8'(i + 32), 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 3'd0);
    check_val("pp_count", 32'(count), 32'd16);
    check_val("pp_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 15; i++) pop();
    check_val("pp_last", 32'(dout), 32'hAA);
    do_flush();

    // Threshold trigger.
    threshold = 5'd8;
    for (int i = 0; i < 7; i++) push(8'(i), 3'd0);
    check_val("thr_low", 32'(thr_trigger), 32'd0);
    push(8'h07, 3'd0);
    check_val("thr_rise", 32'(thr_trigger), 32'd1);
    pop();
    check_val("thr_fall", 32'(thr_trigger), 32'd0);
    do_flush();

    // Error tag tracking.
    push(8'h10, 3'd0);
    push(8'h11, 3'd4);
    push(8'h12, 3'd0);
    check_val("err_set", 32'(err_in_fifo), 32'd1);
    pop();
    check_val("err_keep", 32'(err_in_fifo), 32'd1);
    pop();
    check_val("err_gone", 32'(err_in_fifo), 32'd0);
    push(8'h13, 3'd2);
    do_flush();
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_err", 32'(err_in_fifo), 32'd0);

    // Randomized traffic with wrap-around, en toggling and a mid-run reset.
    for (int i = 0; i < 200; i++) begin
      logic e, f, sc, pu, po;
      if (i == 100) begin
        rst_n = 1'b0;
        #1;
        check_val("arst_empty", 32'(empty), 32'd1);
        check_val("arst_count", 32'(count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (i % 25 == 0) threshold = 5'($urandom_range(0, 17));
      e  = ($urandom_range(0, 9) < 8);
      f  = ($urandom_range(0, 49) == 0);
      sc = ($urandom_range(0, 9) == 0);
      pu = (i % 100 < 60) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
      po = (i % 100 < 60) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      step(e, f, sc, pu, po, 8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
